// File: rtl/instr_fetch_if.sv
// instr_fetch_if: RAM read port, decode handshake and control signals of the fetch stage.
interface instr_fetch_if #(parameter int ADDR_BITS = 8);
  logic                   enable;
  logic [ADDR_BITS-1:0]   addr_read;
  logic [2*ADDR_BITS-1:0] data_read;
  logic [2*ADDR_BITS-1:0] instr;
  logic [ADDR_BITS-1:0]   instr_pc;
  logic                   instr_valid;
  logic                   instr_ready;
  logic                   jump_valid;
  logic [ADDR_BITS-1:0]   jump_target;
  logic                   resume;
  logic                   halted;
  logic                   pc_wrapped;
  modport master (
    input  enable, data_read, instr_ready, jump_valid, jump_target, resume,
    output addr_read, instr, instr_pc, instr_valid, halted, pc_wrapped
  );
  modport slave (
    output enable, data_read, instr_ready, jump_valid, jump_target, resume,
    input  addr_read, instr, instr_pc, instr_valid, halted, pc_wrapped
  );
endinterface

// File: rtl/instr_fetch.sv
// instr_fetch: PC-driven fetch from async-read RAM into a valid/ready instruction register with jump, HALT/resume and wrap flag.
module instr_fetch #(
  parameter int                   ADDR_BITS   = 8,
  parameter logic [ADDR_BITS-1:0] START_ADDR  = '0,
  parameter logic [ADDR_BITS-1:0] HALT_OPCODE = '1
) (
  input logic clock,
  input logic reset,
  instr_fetch_if.master bus
);
  localparam int W = 2 * ADDR_BITS;
  typedef enum logic {RUN, HALTED} state_t;
  state_t               r_state, w_next_state;
  logic [ADDR_BITS-1:0] r_pc, r_instr_pc;
  logic [W-1:0]         r_instr;
  logic                 r_valid, r_wrapped;
  logic                 w_load, w_halt_op, w_wrap;
  always_comb begin
    w_halt_op    = bus.data_read[W-1:ADDR_BITS] == HALT_OPCODE;
    w_load       = r_state == RUN && bus.enable && !bus.jump_valid && (!r_valid || bus.instr_ready);
    w_wrap       = w_load && r_pc == '1;
    w_next_state = (w_load && w_halt_op) ? HALTED : (r_state == HALTED && bus.resume) ? RUN : r_state;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= RUN;
      r_pc       <= START_ADDR;
      r_instr    <= '0;
      r_instr_pc <= '0;
      r_valid    <= 1'b0;
      r_wrapped  <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (w_wrap) r_wrapped <= 1'b1;
      if (bus.jump_valid) begin
        r_pc    <= bus.jump_target;
        r_valid <= 1'b0;
      end else if (w_load) begin
        r_pc    <= r_pc + 1'b1;
        r_valid <= !w_halt_op;
        if (!w_halt_op) begin
          r_instr    <= bus.data_read;
          r_instr_pc <= r_pc;
        end
      end else if (r_valid && bus.instr_ready) begin
        r_valid <= 1'b0;
      end
    end
  end
  assign bus.addr_read   = r_pc;
  assign bus.instr       = r_instr;
  assign bus.instr_pc    = r_instr_pc;
  assign bus.instr_valid = r_valid;
  assign bus.halted      = r_state == HALTED;
  assign bus.pc_wrapped  = r_wrapped;
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: scenario tasks with inline checks plus a scoreboard of {instr_pc, instr} for every accepted instruction.
module tb_instr_fetch;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic [15:0] ram [256];
  logic [23:0] sb [$];
  int n_checks = 0;
  int n_fail = 0;

  instr_fetch_if #(.ADDR_BITS(8)) bus ();
  instr_fetch #(.ADDR_BITS(8), .START_ADDR(8'h00), .HALT_OPCODE(8'hFF)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;
  assign bus.data_read = ram[bus.addr_read];

  // Every accepted instruction must match the oldest expected entry.
  always @(negedge clock) begin
    logic [23:0] exp_e;
    if (!reset && bus.instr_valid && bus.instr_ready) begin
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected: got pc=%h instr=%h, none expected", bus.instr_pc, bus.instr);
      end else begin
        exp_e = sb.pop_front();
        if ({bus.instr_pc, bus.instr} !== exp_e) begin
          n_fail++;
          $display("FAIL sb_accept: got pc=%h instr=%h want pc=%h instr=%h",
                   bus.instr_pc, bus.instr, exp_e[23:16], exp_e[15:0]);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.enable = 1'b0;
    bus.instr_ready = 1'b0;
    bus.jump_valid = 1'b0;
    bus.jump_target = 8'h00;
    bus.resume = 1'b0;
    tick();
    tick();
    n_checks++;
    if ({bus.instr_valid, bus.halted, bus.pc_wrapped} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_flags: got valid/halted/wrapped=%b want 000", {bus.instr_valid, bus.halted, bus.pc_wrapped});
    end
    n_checks++;
    if ({bus.addr_read, bus.instr_pc, bus.instr} !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_regs: got addr=%h pc=%h instr=%h want 0", bus.addr_read, bus.instr_pc, bus.instr);
    end
  endtask

  task automatic test_sequential();
    logic [15:0] words [4];
    words = '{16'h0102, 16'h0304, 16'h0506, 16'h0708};
    reset = 1'b0;
    bus.enable = 1'b1;
    bus.instr_ready = 1'b1;
    for (int i = 0; i < 4; i++) sb.push_back({i[7:0], words[i]});
    n_checks++;
    if (bus.instr_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL seq_first_cycle: got valid=%b want 0", bus.instr_valid);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++;
      if ({bus.instr_valid, bus.instr_pc, bus.instr} !== {1'b1, i[7:0], words[i]}) begin
        n_fail++;
        $display("FAIL seq_word%0d: got v=%b pc=%h instr=%h want v=1 pc=%h instr=%h",
                 i, bus.instr_valid, bus.instr_pc, bus.instr, i[7:0], words[i]);
      end
    end
    bus.enable = 1'b0;
    tick();
    n_checks++;
    if ({bus.instr_valid, bus.addr_read} !== {1'b0, 8'h04}) begin
      n_fail++;
      $display("FAIL en_low_consume: got v=%b addr=%h want v=0 addr=04", bus.instr_valid, bus.addr_read);
    end
    tick();
    n_checks++;
    if (bus.addr_read !== 8'h04) begin
      n_fail++;
      $display("FAIL en_low_hold: got addr=%h want 04", bus.addr_read);
    end
    bus.jump_valid = 1'b1;
    bus.jump_target = 8'h30;
    tick();
    bus.jump_valid = 1'b0;
    n_checks++;
    if (bus.addr_read !== 8'h30) begin
      n_fail++;
      $display("FAIL en_low_jump: got addr=%h want 30", bus.addr_read);
    end
    tick();
    n_checks++;
    if ({bus.instr_valid, bus.addr_read} !== {1'b0, 8'h30}) begin
      n_fail++;
      $display("FAIL en_low_jump_hold: got v=%b addr=%h want v=0 addr=30", bus.instr_valid, bus.addr_read);
    end
  endtask

  task automatic test_stall();
    bus.enable = 1'b1;
    bus.jump_valid = 1'b1;
    bus.jump_target = 8'h00;
    tick();
    bus.jump_valid = 1'b0;
    sb.push_back({8'h00, 16'h0102});
    sb.push_back({8'h01, 16'h0304});
    sb.push_back({8'h02, 16'h0506});
    tick();
    tick();
    n_checks++;
    if ({bus.instr_pc, bus.instr} !== {8'h01, 16'h0304}) begin
      n_fail++;
      $display("FAIL stall_pre: got pc=%h instr=%h want pc=01 instr=0304", bus.instr_pc, bus.instr);
    end
    bus.instr_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if ({bus.instr_valid, bus.instr_pc, bus.instr, bus.addr_read} !== {1'b1, 8'h01, 16'h0304, 8'h02}) begin
        n_fail++;
        $display("FAIL stall_hold%0d: got v=%b pc=%h instr=%h addr=%h want v=1 pc=01 instr=0304 addr=02",
                 i, bus.instr_valid, bus.instr_pc, bus.instr, bus.addr_read);
      end
    end
    bus.instr_ready = 1'b1;
    tick();
    n_checks++;
    if ({bus.instr_valid, bus.instr_pc, bus.instr} !== {1'b1, 8'h02, 16'h0506}) begin
      n_fail++;
      $display("FAIL stall_release: got v=%b pc=%h instr=%h want v=1 pc=02 instr=0506",
               bus.instr_valid, bus.instr_pc, bus.instr);
    end
  endtask

  task automatic test_jump();
    bus.jump_valid = 1'b1;
    bus.jump_target = 8'h40;
    tick();
    bus.jump_valid = 1'b0;
    n_checks++;
    if ({bus.instr_valid, bus.addr_read} !== {1'b0, 8'h40}) begin
      n_fail++;
      $display("FAIL jump_flush: got v=%b addr=%h want v=0 addr=40", bus.instr_valid, bus.addr_read);
    end
    sb.push_back({8'h40, 16'h1111});
    tick();
    n_checks++;
    if ({bus.instr_valid, bus.instr_pc, bus.instr} !== {1'b1, 8'h40, 16'h1111}) begin
      n_fail++;
      $display("FAIL jump_target: got v=%b pc=%h instr=%h want v=1 pc=40 instr=1111",
               bus.instr_valid, bus.instr_pc, bus.instr);
    end
    bus.enable = 1'b0;
    tick();
  endtask

  task automatic test_halt();
    bus.enable = 1'b1;
    bus.resume = 1'b1;
    n_checks++;
    if (bus.halted !== 1'b0) begin
      n_fail++;
      $display("FAIL resume_in_run_pre: got halted=%b want 0", bus.halted);
    end
    bus.jump_valid = 1'b1;
    bus.jump_target = 8'h04;
    tick();
    bus.jump_valid = 1'b0;
    bus.resume = 1'b0;
    sb.push_back({8'h04, 16'h0910});
    tick();
    n_checks++;
    if ({bus.instr_valid, bus.instr_pc, bus.instr, bus.halted} !== {1'b1, 8'h04, 16'h0910, 1'b0}) begin
      n_fail++;
      $display("FAIL halt_pre: got v=%b pc=%h instr=%h halted=%b want v=1 pc=04 instr=0910 halted=0",
               bus.instr_valid, bus.instr_pc, bus.instr, bus.halted);
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      n_checks++;
      if ({bus.halted, bus.instr_valid, bus.addr_read} !== {1'b1, 1'b0, 8'h06}) begin
        n_fail++;
        $display("FAIL halted%0d: got halted=%b v=%b addr=%h want halted=1 v=0 addr=06",
                 i, bus.halted, bus.instr_valid, bus.addr_read);
      end
    end
    bus.resume = 1'b1;
    tick();
    bus.resume = 1'b0;
    n_checks++;
    if ({bus.halted, bus.instr_valid, bus.addr_read} !== {1'b0, 1'b0, 8'h06}) begin
      n_fail++;
      $display("FAIL resume: got halted=%b v=%b addr=%h want halted=0 v=0 addr=06",
               bus.halted, bus.instr_valid, bus.addr_read);
    end
    sb.push_back({8'h06, 16'h0A0B});
    tick();
    n_checks++;
    if ({bus.instr_valid, bus.instr_pc, bus.instr} !== {1'b1, 8'h06, 16'h0A0B}) begin
      n_fail++;
      $display("FAIL resume_fetch: got v=%b pc=%h instr=%h want v=1 pc=06 instr=0A0B",
               bus.instr_valid, bus.instr_pc, bus.instr);
    end
    bus.enable = 1'b0;
    tick();
  endtask

  task automatic test_wrap();
    bus.enable = 1'b1;
    bus.jump_valid = 1'b1;
    bus.jump_target = 8'hFE;
    tick();
    bus.jump_valid = 1'b0;
    sb.push_back({8'hFE, 16'h1234});
    sb.push_back({8'hFF, 16'h5678});
    sb.push_back({8'h00, 16'h0102});
    tick();
    n_checks++;
    if ({bus.instr_pc, bus.instr, bus.pc_wrapped} !== {8'hFE, 16'h1234, 1'b0}) begin
      n_fail++;
      $display("FAIL wrap_fe: got pc=%h instr=%h wrapped=%b want pc=fe instr=1234 wrapped=0",
               bus.instr_pc, bus.instr, bus.pc_wrapped);
    end
    tick();
    n_checks++;
    if ({bus.instr_pc, bus.instr, bus.pc_wrapped, bus.addr_read} !== {8'hFF, 16'h5678, 1'b1, 8'h00}) begin
      n_fail++;
      $display("FAIL wrap_ff: got pc=%h instr=%h wrapped=%b addr=%h want pc=ff instr=5678 wrapped=1 addr=00",
               bus.instr_pc, bus.instr, bus.pc_wrapped, bus.addr_read);
    end
    tick();
    n_checks++;
    if ({bus.instr_pc, bus.instr} !== {8'h00, 16'h0102}) begin
      n_fail++;
      $display("FAIL wrap_00: got pc=%h instr=%h want pc=00 instr=0102", bus.instr_pc, bus.instr);
    end
    bus.enable = 1'b0;
    bus.jump_valid = 1'b1;
    bus.jump_target = 8'h10;
    tick();
    bus.jump_valid = 1'b0;
    n_checks++;
    if ({bus.pc_wrapped, bus.addr_read, bus.instr_valid} !== {1'b1, 8'h10, 1'b0}) begin
      n_fail++;
      $display("FAIL wrap_sticky: got wrapped=%b addr=%h v=%b want wrapped=1 addr=10 v=0",
               bus.pc_wrapped, bus.addr_read, bus.instr_valid);
    end
  endtask

  task automatic test_reset_mid();
    bus.enable = 1'b1;
    bus.instr_ready = 1'b0;
    tick();
    bus.enable = 1'b0;
    n_checks++;
    if ({bus.instr_valid, bus.halted, bus.instr_pc, bus.instr} !== {1'b1, 1'b0, 8'h10, 16'h2010}) begin
      n_fail++;
      $display("FAIL mid_pre: got v=%b halted=%b pc=%h instr=%h want v=1 halted=0 pc=10 instr=2010",
               bus.instr_valid, bus.halted, bus.instr_pc, bus.instr);
    end
    reset = 1'b1;
    tick();
    n_checks++;
    if ({bus.instr_valid, bus.addr_read, bus.pc_wrapped, bus.instr_pc, bus.instr} !== 34'h0) begin
      n_fail++;
      $display("FAIL mid_reset: got v=%b addr=%h wrapped=%b pc=%h instr=%h want all 0",
               bus.instr_valid, bus.addr_read, bus.pc_wrapped, bus.instr_pc, bus.instr);
    end
    reset = 1'b0;
    tick();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ram[i] = {8'h20, i[7:0]};
    ram[8'h00] = 16'h0102;
    ram[8'h01] = 16'h0304;
    ram[8'h02] = 16'h0506;
    ram[8'h03] = 16'h0708;
    ram[8'h04] = 16'h0910;
    ram[8'h05] = 16'hFF00;
    ram[8'h06] = 16'h0A0B;
    ram[8'h40] = 16'h1111;
    ram[8'hFE] = 16'h1234;
    ram[8'hFF] = 16'h5678;
    test_reset();
    test_sequential();
    test_stall();
    test_jump();
    test_halt();
    test_wrap();
    test_reset_mid();
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: got %0d pending want 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Fetch stage that sits directly downstream of the processor's instruction RAM.
- Drives the RAM read address from a program counter and captures the asynchronous read word into an instruction register.
- Presents the instruction to decode with a valid/ready handshake.
- Handles jump redirects, a HALT opcode and resume, and flags PC wrap-around.

Parameters:
- ADDR_BITS, 8, RAM address width; the instruction word is 2*ADDR_BITS wide.
- START_ADDR, 0, PC value loaded on reset.
- HALT_OPCODE, all ones (2**ADDR_BITS-1), opcode field value that halts fetch.

Ports:
- clock  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  fetch enable; when low, no new fetch and PC holds.
- addr_read  out  ADDR_BITS  RAM read address; always equals the current PC.
- data_read  in  2*ADDR_BITS  RAM read data, combinational from addr_read.
- instr  out  2*ADDR_BITS  registered instruction word: opcode = [2*ADDR_BITS-1:ADDR_BITS], operand = [ADDR_BITS-1:0].
- instr_pc  out  ADDR_BITS  address the current instr was fetched from.
- instr_valid  out  1  instr/instr_pc hold an unconsumed instruction.
- instr_ready  in  1  decode accepts instr this cycle.
- jump_valid  in  1  redirect request.
- jump_target  in  ADDR_BITS  new PC on redirect.
- resume  in  1  leave HALTED state.
- halted  out  1  high in HALTED state.
- pc_wrapped  out  1  sticky; set when PC increments from 2**ADDR_BITS-1 to 0.

Behaviour:
- Reset (synchronous, active-high, priority over everything):
  - pc = START_ADDR; state = RUN.
  - instr_valid = 0, instr = 0, instr_pc = 0, halted = 0, pc_wrapped = 0.
  - Reset mid-operation discards any held instruction.
- States: RUN, HALTED. halted = (state == HALTED).
- Load condition: state == RUN, enable == 1, jump_valid == 0, and (instr_valid == 0 or instr_ready == 1).
- On a load:
  - If data_read opcode != HALT_OPCODE: instr <= data_read, instr_pc <= pc, instr_valid <= 1, pc <= pc + 1.
  - If data_read opcode == HALT_OPCODE: the word is not presented; instr_valid <= 0, pc <= pc + 1, state <= HALTED.
- Handshake:
  - Consumption happens when instr_valid && instr_ready.
  - A consumption with no new load clears instr_valid.
  - While instr_valid == 1 && instr_ready == 0, instr, instr_pc and pc hold.
- Latency:
  - The word at PC n appears on instr with instr_valid = 1 one cycle after addr_read == n and the load condition is true.
  - Throughput is one instruction per cycle while instr_ready stays high.
  - First valid instruction appears in the second cycle after reset deasserts.
- Jump (honoured in any state, any enable):
  - pc <= jump_target; instr_valid <= 0 (flush).
  - A same-cycle handshake counts as consumed.
  - No load occurs in the jump cycle.
  - The target word is loaded the following cycle if the load condition holds.
  - A jump does not change state.
- HALTED:
  - No loads; instr_valid stays 0.
  - resume == 1 → state <= RUN; fetch restarts the next cycle from the current pc, i.e. HALT address + 1 unless a jump moved it.
  - jump_valid and resume in the same cycle: pc <= jump_target and state <= RUN.
  - resume in RUN is ignored.
- Enable low: no load and pc holds. Handshake consumption still clears instr_valid. Jump still applies.
- Wrap-around:
  - pc + 1 is modulo 2**ADDR_BITS.
  - An increment from all-ones to 0 (normal or HALT load) sets pc_wrapped, which stays set until reset.
  - A jump to 0 does not set it.

Test Plan:
- Reset, then RAM[0..3] = 0x0102, 0x0304, 0x0506, 0x0708 with instr_ready = 1 → instr_valid rises in the 2nd post-reset cycle; instr = 0x0102, 0x0304, 0x0506, 0x0708 on consecutive cycles with instr_pc 0..3.
- instr_ready low for 3 cycles while instr = 0x0304 → instr, instr_pc = 1 and addr_read = 2 held; after ready rises, next instr = 0x0506.
- At instr_pc = 2, assert jump_valid with jump_target = 0x40 and RAM[0x40] = 0x1111 → next cycle instr_valid = 0 and addr_read = 0x40; the cycle after, instr = 0x1111 with instr_pc = 0x40.
- RAM[5] = 0xFF00 (HALT) → after instr_pc = 4 is consumed: halted = 1, instr_valid stays 0, addr_read = 6; pulse resume → instr = RAM[6] one cycle later.
- Jump to 0xFE with RAM[0xFE], RAM[0xFF] and RAM[0] non-HALT → instr_pc sequence 0xFE, 0xFF, 0x00; pc_wrapped = 1 after the 0xFF load; stays 1 through a later jump to 0x10.
- Assert reset while instr_valid = 1 and halted = 0 → next cycle instr_valid = 0, addr_read = START_ADDR, pc_wrapped = 0; also check that enable = 0 freezes addr_read while a jump still moves it.
